// File: rtl/update_sched_pkg.sv
// hft_pkg: shared widths, defaults, state encoding and update record for the update scheduler
package hft_pkg;
   localparam int PRED_WIDTH = 7;
   localparam int WEIGHT_WIDTH = 15;
   localparam int NODE_W = PRED_WIDTH + 1;
   localparam int EDGE_W = WEIGHT_WIDTH + 1;
   localparam int DEF_FIFO_DEPTH = 8;
   localparam int DEF_TIMEOUT = 4096;
   typedef logic [1:0] sched_state_t;
   localparam sched_state_t IDLE = 2'd0;
   localparam sched_state_t START = 2'd1;
   localparam sched_state_t RUN = 2'd2;
   localparam sched_state_t ERR = 2'd3;
   typedef struct packed {
      logic [NODE_W-1:0] src;
      logic [NODE_W-1:0] dst;
      logic [EDGE_W-1:0] e;
   } upd_t;
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
endpackage

// File: rtl/update_sched_if.sv
// update_sched_if: host edge-update handshake bundle
interface update_sched_if;
   import hft_pkg::*;
   logic upd_valid;
   logic upd_ready;
   logic [NODE_W-1:0] upd_src;
   logic [NODE_W-1:0] upd_dst;
   logic [EDGE_W-1:0] upd_e;
   modport master(output upd_valid, upd_src, upd_dst, upd_e, input upd_ready);
   modport slave(input upd_valid, upd_src, upd_dst, upd_e, output upd_ready);
endinterface

// File: rtl/update_sched_fifo.sv
// upd_fifo: synchronous power-of-two FIFO of edge updates with a show-ahead head
module upd_fifo import hft_pkg::*; #(
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic pop,
   input  upd_t din,
   output upd_t head,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);
   upd_t mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0] cnt_q, cnt_d;
   logic do_push, do_pop;
   always_comb begin
      do_push = push && !full;
      do_pop = pop && !empty;
      wr_d = wr_q + AW'(do_push);
      rd_d = rd_q + AW'(do_pop);
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= din;
   assign head = mem_q[rd_q];
   assign full = cnt_q[AW];
   assign empty = cnt_q == '0;
endmodule

// File: rtl/update_sched.sv
// update_sched: queues host edge updates and issues them one at a time to the container with a hang timeout
module update_sched import hft_pkg::*; #(
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   update_sched_if.slave upd,
   output logic container_reset,
   output logic [NODE_W-1:0] u_src,
   output logic [NODE_W-1:0] u_dst,
   output logic [EDGE_W-1:0] u_e,
   input  logic container_done,
   output logic busy,
   output logic err,
   input  logic err_clr,
   output logic [15:0] run_count,
   output logic [15:0] rej_count
);
   localparam int TW = $clog2(TIMEOUT);
   sched_state_t state_q, state_d;
   upd_t cur_q, cur_d, head, upd_in;
   logic [TW-1:0] timer_q, timer_d;
   logic [15:0] run_q, run_d, rej_q, rej_d;
   logic cr_q, cr_d, err_q, err_d;
   logic full, empty, accept, push, pop, timeout;
   upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .din(upd_in),
      .head(head), .full(full), .empty(empty)
   );
   assign upd.upd_ready = !full;
   assign upd_in = upd_t'{upd.upd_src, upd.upd_dst, upd.upd_e};
   assign accept = upd.upd_valid && !full;
   assign push = accept && (upd.upd_src != upd.upd_dst);
   assign pop = (state_q == IDLE) && !empty;
   assign timeout = (state_q == RUN) && !container_done && (timer_q == TW'(TIMEOUT - 1));
   always_comb begin
      state_d = state_q;
      cur_d = cur_q;
      timer_d = timer_q;
      run_d = run_q;
      rej_d = (accept && !push) ? sat_inc(rej_q) : rej_q;
      case (state_q)
         IDLE: if (!empty) begin
            cur_d = head;
            state_d = START;
         end
         START: begin
            timer_d = '0;
            state_d = RUN;
         end
         RUN: if (container_done) begin
            run_d = sat_inc(run_q);
            state_d = IDLE;
         end else if (timeout) state_d = ERR;
         else timer_d = timer_q + 1'b1;
         default: if (err_clr) state_d = IDLE;
      endcase
      // one pulse per issue, plus one abort pulse on the way into ERR
      cr_d = (state_d == START) || timeout;
      err_d = timeout ? 1'b1 : (err_clr ? 1'b0 : err_q);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cur_q <= '0;
         timer_q <= '0;
         run_q <= '0;
         rej_q <= '0;
         cr_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q <= cur_d;
         timer_q <= timer_d;
         run_q <= run_d;
         rej_q <= rej_d;
         cr_q <= cr_d;
         err_q <= err_d;
      end
   end
   assign container_reset = cr_q;
   assign u_src = cur_q.src;
   assign u_dst = cur_q.dst;
   assign u_e = cur_q.e;
   assign busy = (state_q != IDLE) || !empty;
   assign err = err_q;
   assign run_count = run_q;
   assign rej_count = rej_q;
endmodule

// File: tb/tb_update_sched.sv
// tb_update_sched: randomized bench comparing update_sched against an in-order queue model and a container responder
module tb_update_sched;
   import hft_pkg::*;
   localparam int DEPTH = 8;
   localparam int TMO = 64;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic container_reset, container_done, busy, err, err_clr;
   logic [NODE_W-1:0] u_src, u_dst;
   logic [EDGE_W-1:0] u_e;
   logic [15:0] run_count, rej_count;
   int checks = 0, errors = 0;
   int cyc = 0, done_lat = 0, issues = 0, aborts = 0, abort_cyc = 0, last_issue = 0, pw_viol = 0;
   int exp_run = 0, exp_rej = 0;
   logic prev_cr = 1'b0;
   upd_t got_q[$], exp_q[$];
   int issue_cyc[$];
   update_sched_if uif();
   update_sched #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .upd(uif), .container_reset(container_reset),
      .u_src(u_src), .u_dst(u_dst), .u_e(u_e), .container_done(container_done),
      .busy(busy), .err(err), .err_clr(err_clr), .run_count(run_count), .rej_count(rej_count)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (container_reset && prev_cr) pw_viol++;
      if (container_reset && err) begin
         aborts++;
         abort_cyc = cyc;
      end else if (container_reset) begin
         issues++;
         last_issue = cyc;
         issue_cyc.push_back(cyc);
         got_q.push_back(upd_t'{u_src, u_dst, u_e});
      end
      prev_cr = container_reset;
   end
   // container model: done rises done_lat cycles after an issue pulse and stays high one cycle into the next run
   initial begin
      int cnt;
      logic active, clr_pend;
      container_done = 1'b0;
      cnt = 0;
      active = 1'b0;
      clr_pend = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            container_done = 1'b0;
            active = 1'b0;
            clr_pend = 1'b0;
         end else begin
            if (clr_pend) begin
               container_done = 1'b0;
               clr_pend = 1'b0;
            end
            if (container_reset) begin
               clr_pend = 1'b1;
               cnt = 0;
               active = !err;
            end else if (active && done_lat > 0 && !container_done) begin
               cnt++;
               if (cnt >= done_lat) container_done = 1'b1;
            end
         end
      end
   end
   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   task automatic tick();
      @(negedge clk);
      #1;
   endtask
   task automatic push(input logic [NODE_W-1:0] s, input logic [NODE_W-1:0] d, input logic [EDGE_W-1:0] e);
      int w;
      w = 0;
      uif.upd_valid = 1'b1;
      uif.upd_src = s;
      uif.upd_dst = d;
      uif.upd_e = e;
      while (!uif.upd_ready && w < 500) begin
         tick();
         w++;
      end
      if (!uif.upd_ready) begin
         checks++;
         errors++;
         $display("FAIL push_ready: upd_ready=0 after %0d cycles, required 1", w);
      end else begin
         tick();
         if (s != d) exp_q.push_back(upd_t'{s, d, e});
         else if (exp_rej < 65535) exp_rej++;
      end
      uif.upd_valid = 1'b0;
   endtask
   task automatic wait_idle(input int budget);
      int w;
      w = 0;
      while (busy && w < budget) begin
         tick();
         w++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, budget);
      end
   endtask
   task automatic wait_issues(input int n, input int budget);
      int w;
      w = 0;
      while (issues < n && w < budget) begin
         tick();
         w++;
      end
      if (issues < n) begin
         checks++;
         errors++;
         $display("FAIL wait_issue: issues=%0d after %0d cycles, required %0d", issues, budget, n);
      end
   endtask
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      checks++; if (container_reset !== 1'b0) begin errors++; $display("FAIL reset_cr: got %b want 0", container_reset); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
      checks++; if (uif.upd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", uif.upd_ready); end
      checks++; if ({u_src, u_dst, u_e} !== '0) begin errors++; $display("FAIL reset_u: got %h/%h/%h want 0", u_src, u_dst, u_e); end
      checks++; if (run_count !== 16'd0) begin errors++; $display("FAIL reset_run: got %0d want 0", run_count); end
      checks++; if (rej_count !== 16'd0) begin errors++; $display("FAIL reset_rej: got %0d want 0", rej_count); end
      reset = 1'b0;
      tick();
   endtask
   task automatic test_single();
      int n0;
      n0 = issues;
      done_lat = 20;
      push(NODE_W'(3), NODE_W'(5), EDGE_W'(16'h10));
      wait_issues(n0 + 1, 20);
      tick();
      checks++; if ({u_src, u_dst, u_e} !== {NODE_W'(3), NODE_W'(5), EDGE_W'(16'h10)}) begin errors++; $display("FAIL single_u_run: got %0d/%0d/%h want 3/5/10", u_src, u_dst, u_e); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_run: got %b want 1", busy); end
      wait_idle(200);
      exp_run += 1;
      checks++; if (run_count !== 16'(exp_run)) begin errors++; $display("FAIL single_run_count: got %0d want %0d", run_count, exp_run); end
      checks++; if (issues !== n0 + 1) begin errors++; $display("FAIL single_issues: got %0d want %0d", issues, n0 + 1); end
      checks++; if ({u_src, u_dst, u_e} !== {NODE_W'(3), NODE_W'(5), EDGE_W'(16'h10)}) begin errors++; $display("FAIL single_u_hold: got %0d/%0d/%h want 3/5/10", u_src, u_dst, u_e); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL single_count: got %0d issued want %0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      got_q.delete();
      exp_q.delete();
   endtask
   task automatic test_reject();
      int n0;
      n0 = issues;
      push(NODE_W'(4), NODE_W'(4), EDGE_W'(16'h77));
      repeat (10) tick();
      checks++; if (rej_count !== 16'(exp_rej)) begin errors++; $display("FAIL reject_count: got %0d want %0d", rej_count, exp_rej); end
      checks++; if (issues !== n0) begin errors++; $display("FAIL reject_issue: got %0d issues want %0d", issues, n0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reject_busy: got %b want 0", busy); end
      checks++; if (uif.upd_ready !== 1'b1) begin errors++; $display("FAIL reject_ready: got %b want 1", uif.upd_ready); end
   endtask
   task automatic test_back_to_back();
      int n0;
      n0 = issues;
      done_lat = 0;
      issue_cyc.delete();
      for (int i = 0; i < DEPTH + 1; i++) push(NODE_W'(i + 1), NODE_W'(i + 9), EDGE_W'(16'h100 + i));
      checks++; if (uif.upd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: upd_ready got %b want 0", uif.upd_ready); end
      checks++; if (issues !== n0 + 1) begin errors++; $display("FAIL b2b_inflight: got %0d issues want %0d", issues, n0 + 1); end
      uif.upd_valid = 1'b1;
      uif.upd_src = NODE_W'(20);
      uif.upd_dst = NODE_W'(21);
      repeat (4) begin
         tick();
         checks++; if (uif.upd_ready !== 1'b0) begin errors++; $display("FAIL b2b_hold_full: upd_ready got %b want 0", uif.upd_ready); end
      end
      uif.upd_valid = 1'b0;
      done_lat = 3;
      wait_idle(500);
      exp_run += DEPTH + 1;
      checks++; if (run_count !== 16'(exp_run)) begin errors++; $display("FAIL b2b_run_count: got %0d want %0d", run_count, exp_run); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d issued want %0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      for (int i = 2; i < issue_cyc.size(); i++) begin
         checks++; if (issue_cyc[i] - issue_cyc[i-1] !== 5) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d cycles want 5", i, issue_cyc[i] - issue_cyc[i-1]); end
      end
      got_q.delete();
      exp_q.delete();
   endtask
   task automatic test_timeout();
      int n0, a0, c;
      n0 = issues;
      a0 = aborts;
      done_lat = 0;
      push(NODE_W'(1), NODE_W'(2), EDGE_W'(16'h33));
      wait_issues(n0 + 1, 20);
      c = last_issue;
      push(NODE_W'(6), NODE_W'(7), EDGE_W'(16'h44));
      while (cyc < c + TMO) tick();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_early: err got %b want 0 at run cycle %0d", err, TMO); end
      err_clr = 1'b1;
      tick();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b want 1", err); end
      checks++; if (container_reset !== 1'b1) begin errors++; $display("FAIL tmo_abort: container_reset got %b want 1", container_reset); end
      checks++; if (abort_cyc !== c + TMO + 1 || aborts !== a0 + 1) begin errors++; $display("FAIL tmo_abort_cyc: got cyc %0d count %0d want cyc %0d count %0d", abort_cyc, aborts, c + TMO + 1, a0 + 1); end
      err_clr = 1'b0;
      repeat (5) tick();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: err got %b want 1", err); end
      checks++; if (issues !== n0 + 1) begin errors++; $display("FAIL tmo_hold: got %0d issues want %0d", issues, n0 + 1); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_busy: got %b want 1", busy); end
      done_lat = 4;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      wait_idle(300);
      exp_run += 1;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_clr: err got %b want 0", err); end
      checks++; if (run_count !== 16'(exp_run)) begin errors++; $display("FAIL tmo_run_count: got %0d want %0d", run_count, exp_run); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL tmo_count: got %0d issued want %0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL tmo_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      got_q.delete();
      exp_q.delete();
   endtask
   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         done_lat = int'($urandom_range(1, 6));
         push(NODE_W'($urandom_range(0, 3)), NODE_W'($urandom_range(0, 3)), EDGE_W'($urandom));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 8)) tick();
      end
      wait_idle(3000);
      exp_run += exp_q.size();
      checks++; if (run_count !== 16'(exp_run)) begin errors++; $display("FAIL rand_run_count: got %0d want %0d", run_count, exp_run); end
      checks++; if (rej_count !== 16'(exp_rej)) begin errors++; $display("FAIL rand_rej_count: got %0d want %0d", rej_count, exp_rej); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d issued want %0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      got_q.delete();
      exp_q.delete();
   endtask
   task automatic test_reset_mid_run();
      int n1;
      done_lat = 0;
      for (int i = 0; i < 4; i++) push(NODE_W'(i + 2), NODE_W'(i + 12), EDGE_W'(16'hA0 + i));
      repeat (3) tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_busy: got %b want 1", busy); end
      reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
      checks++; if (container_reset !== 1'b0) begin errors++; $display("FAIL rst_mid_cr: got %b want 0", container_reset); end
      checks++; if ({u_src, u_dst, u_e} !== '0) begin errors++; $display("FAIL rst_mid_u: got %h/%h/%h want 0", u_src, u_dst, u_e); end
      checks++; if (run_count !== 16'd0 || rej_count !== 16'd0) begin errors++; $display("FAIL rst_mid_counts: got run %0d rej %0d want 0/0", run_count, rej_count); end
      checks++; if (uif.upd_ready !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: got ready %b err %b want 1/0", uif.upd_ready, err); end
      repeat (2) tick();
      reset = 1'b0;
      got_q.delete();
      exp_q.delete();
      exp_run = 0;
      exp_rej = 0;
      n1 = issues;
      repeat (30) tick();
      checks++; if (issues !== n1) begin errors++; $display("FAIL rst_mid_no_issue: got %0d issues want %0d", issues, n1); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: busy got %b want 0", busy); end
   endtask
   initial begin
      uif.upd_valid = 1'b0;
      uif.upd_src = '0;
      uif.upd_dst = '0;
      uif.upd_e = '0;
      err_clr = 1'b0;
      test_reset();
      test_single();
      test_reject();
      test_back_to_back();
      test_timeout();
      test_random();
      test_reset_mid_run();
      checks++; if (pw_viol !== 0) begin errors++; $display("FAIL pulse_width: %0d multi-cycle container_reset pulses, want 0", pw_viol); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
